// File: rtl/gap_wall_gen.sv
// Horizontal playfield wall with a movable, width-selectable gap that bounces once per frame.
// Wall output is registered one cycle behind px/py; gap motion runs off the frame pulse.
module gap_wall_gen #(
  parameter int XW       = 10,
  parameter int Y_TOP    = 228,
  parameter int THICK    = 9,
  parameter int X_MIN    = 10,
  parameter int X_MAX    = 629,
  parameter int LOAD_X   = 200,
  parameter int STEP     = 1,
  parameter int SEL_W    = 3,
  parameter int GAP_UNIT = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             frame,
  input  logic             start,
  input  logic             load,
  input  logic             run,
  input  logic             flash,
  input  logic [SEL_W-1:0] gap_sel,
  input  logic [XW-1:0]    px,
  input  logic [XW-1:0]    py,
  output logic             wall,
  output logic [XW-1:0]    gap_x,
  output logic             dir_right,
  output logic [7:0]       bounces
);

  localparam logic [XW:0]   XMIN_W  = (XW+1)'(X_MIN);
  localparam logic [XW:0]   XMAX_W  = (XW+1)'(X_MAX);
  localparam logic [XW:0]   XMAX1_W = (XW+1)'(X_MAX + 1);
  localparam logic [XW:0]   STEP_W  = (XW+1)'(STEP);
  localparam logic [XW:0]   YT_W    = (XW+1)'(Y_TOP);
  localparam logic [XW:0]   YB_W    = (XW+1)'(Y_TOP + THICK - 1);
  localparam logic [XW-1:0] LOAD_V  = XW'(LOAD_X);
  localparam logic [XW-1:0] XMIN_V  = XW'(X_MIN);

  typedef enum logic [1:0] {IDLE, RIGHT, LEFT} state_t;

  state_t          state, state_nx;
  logic [XW-1:0]   gap_w, gap_w_nx, gap_x_nx, sel_w;
  logic [7:0]      bounces_nx, bump;
  logic [XW:0]     lim, gxe, pxe, pye;
  logic            in_row, in_col, in_gap, hit;

  assign sel_w     = XW'(gap_sel * GAP_UNIT);
  // Motion only happens on a frame pulse, which also loads the new width,
  // so the limit is always formed from the incoming width.
  assign lim       = XMAX1_W - {1'b0, sel_w};
  assign gxe       = {1'b0, gap_x};
  assign bump      = (bounces == 8'hFF) ? bounces : bounces + 8'd1;
  assign dir_right = (state == RIGHT);

  always_comb begin
    state_nx   = state;
    gap_x_nx   = gap_x;
    gap_w_nx   = gap_w;
    bounces_nx = bounces;
    if (load) begin
      gap_x_nx   = LOAD_V;
      state_nx   = IDLE;
      bounces_nx = 8'd0;
      gap_w_nx   = sel_w;
    end else begin
      if (frame) gap_w_nx = sel_w;
      if (state == IDLE && start) begin
        state_nx = RIGHT;
      end else if (frame && run && state != IDLE) begin
        case (state)
          RIGHT: begin
            if (gxe + STEP_W >= lim) begin
              gap_x_nx   = lim[XW-1:0];
              state_nx   = LEFT;
              bounces_nx = bump;
            end else begin
              gap_x_nx = XW'(gxe + STEP_W);
            end
          end
          LEFT: begin
            if (gxe > lim) begin
              gap_x_nx = lim[XW-1:0];
            end else if (gxe < XMIN_W + STEP_W) begin
              gap_x_nx   = XMIN_V;
              state_nx   = RIGHT;
              bounces_nx = bump;
            end else begin
              gap_x_nx = XW'(gxe - STEP_W);
            end
          end
          default: state_nx = IDLE;
        endcase
      end
    end
  end

  assign pxe    = {1'b0, px};
  assign pye    = {1'b0, py};
  assign in_row = (pye >= YT_W) && (pye <= YB_W);
  assign in_col = (pxe >= XMIN_W) && (pxe <= XMAX_W);
  assign in_gap = (gap_w != '0) && (pxe >= gxe) && (pxe < gxe + {1'b0, gap_w});
  assign hit    = in_row && in_col && !in_gap;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      gap_x   <= LOAD_V;
      gap_w   <= '0;
      bounces <= 8'd0;
      wall    <= 1'b0;
    end else begin
      state   <= state_nx;
      gap_x   <= gap_x_nx;
      gap_w   <= gap_w_nx;
      bounces <= bounces_nx;
      wall    <= hit && (run || flash);
    end
  end

endmodule

// File: tb/tb_gap_wall_gen.sv
// Scoreboard bench for gap_wall_gen: stimulus queues expected values, a negedge monitor checks them.
// A second, narrow instance exercises bounce-counter saturation in a short run.
module tb_gap_wall_gen;

  logic       clk = 1'b0;
  logic       reset, frame, start, load, run, flash;
  logic [2:0] gap_sel;
  logic [9:0] px, py;
  logic       wall, dir_right, wall2, dir2;
  logic [9:0] gap_x, gap_x2;
  logic [7:0] bounces, bounces2;

  gap_wall_gen dut (
    .clk(clk), .reset(reset), .frame(frame), .start(start), .load(load),
    .run(run), .flash(flash), .gap_sel(gap_sel), .px(px), .py(py),
    .wall(wall), .gap_x(gap_x), .dir_right(dir_right), .bounces(bounces)
  );

  // Span 10..13 with zero gap width: one round trip is 9 frames.
  gap_wall_gen #(.X_MAX(13), .LOAD_X(12), .GAP_UNIT(0)) dut2 (
    .clk(clk), .reset(reset), .frame(frame), .start(start), .load(load),
    .run(run), .flash(flash), .gap_sel(gap_sel), .px(px), .py(py),
    .wall(wall2), .gap_x(gap_x2), .dir_right(dir2), .bounces(bounces2)
  );

  always #5 clk = ~clk;

  typedef struct {int cyc; int kind; int val;} exp_t;
  exp_t  q[$];
  string nq[$];
  int    cyc = 0;
  int    checks = 0;
  int    errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t  e;
      string n;
      int    got;
      e = q.pop_front();
      n = nq.pop_front();
      case (e.kind)
        0:       got = int'(gap_x);
        1:       got = int'(dir_right);
        2:       got = int'(bounces);
        3:       got = int'(wall);
        default: got = int'(bounces2);
      endcase
      checks++;
      if (got != e.val) begin
        errors++;
        $display("FAIL %s: got %0d expected %0d (cycle %0d)", n, got, e.val, cyc);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input int kind, input int val, input string name);
    exp_t e;
    e.cyc = cyc; e.kind = kind; e.val = val;
    q.push_back(e);
    nq.push_back(name);
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      frame = 1'b1;
      step();
      frame = 1'b0;
    end
  endtask

  task automatic do_load();
    load = 1'b1; step(); load = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic pix(input int x, input int y, input int exp_w, input string name);
    px = 10'(x); py = 10'(y);
    step();
    chk(3, exp_w, name);
  endtask

  initial begin
    reset = 1'b1; frame = 1'b0; start = 1'b0; load = 1'b0;
    run = 1'b0; flash = 1'b0; gap_sel = 3'd0; px = '0; py = '0;
    step(); step();
    chk(0, 200, "rst_gap_x"); chk(1, 0, "rst_dir"); chk(2, 0, "rst_bounces"); chk(3, 0, "rst_wall");
    reset = 1'b0;

    // Load width 96, start, ten frames of motion
    run = 1'b1; gap_sel = 3'd3;
    do_load();
    chk(0, 200, "load_gap_x"); chk(1, 0, "load_idle");
    do_start();
    chk(1, 1, "start_right");
    frames(10);
    chk(0, 210, "f10_gap_x"); chk(1, 1, "f10_dir"); chk(2, 0, "f10_bounces");

    // Right-edge reversal at LIM = 630-96 = 534
    do_load(); do_start();
    frames(333);
    chk(0, 533, "f333_gap_x"); chk(2, 0, "f333_bounces");
    frames(1);
    chk(0, 534, "f334_gap_x"); chk(1, 0, "f334_left"); chk(2, 1, "f334_bounces");
    frames(1);
    chk(0, 533, "f335_gap_x");

    // Hit map with gap 200..295, rows 228..236, columns 10..629
    do_load();
    pix(250, 230, 0, "in_gap");
    pix(296, 230, 1, "gap_right_edge");
    pix(295, 230, 0, "gap_last_col");
    pix(199, 230, 1, "gap_left_edge");
    pix(9,   230, 0, "left_of_wall");
    pix(629, 236, 1, "right_bottom_corner");
    pix(630, 236, 0, "right_of_wall");
    pix(300, 237, 0, "below_wall");
    pix(300, 227, 0, "above_wall");
    pix(10,  228, 1, "left_top_corner");

    // Frozen: frames ignored for motion, wall follows flash
    do_start();
    run = 1'b0; px = 10'd300; py = 10'd230;
    for (int i = 0; i < 5; i++) begin
      flash = (i % 2 == 0);
      frames(1);
      chk(3, (i % 2 == 0) ? 1 : 0, "flash_wall");
    end
    chk(0, 200, "frozen_gap_x"); chk(1, 1, "frozen_dir");
    flash = 1'b0;

    // Zero width: run right to 630, then left down to the X_MIN reversal
    run = 1'b1; gap_sel = 3'd0;
    frames(430);
    chk(0, 630, "w0_right_lim"); chk(1, 0, "w0_left"); chk(2, 1, "w0_b1");
    frames(619);
    chk(0, 11, "left_at_11"); chk(1, 0, "left_dir");
    frames(1);
    chk(0, 10, "left_at_10"); chk(1, 0, "left_dir_10"); chk(2, 1, "left_b_10");
    frames(1);
    chk(0, 10, "bounce_min"); chk(1, 1, "bounce_right"); chk(2, 2, "bounce_cnt");

    // Saturation on the narrow instance
    do_load(); do_start();
    frames(1144);
    chk(4, 254, "sat_254");
    frames(1);
    chk(4, 255, "sat_255");
    frames(20);
    chk(4, 255, "sat_hold");

    // Reset mid-motion at gap_x=400
    do_load(); do_start();
    frames(200);
    chk(0, 400, "pre_rst_gap_x"); chk(1, 1, "pre_rst_dir");
    px = 10'd300; py = 10'd230;
    reset = 1'b1; step(); reset = 1'b0;
    chk(0, 200, "mid_rst_gap_x"); chk(1, 0, "mid_rst_idle");
    chk(2, 0, "mid_rst_bounces"); chk(3, 0, "mid_rst_wall");

    // Solid row after reset (gap width 0)
    pix(200, 230, 1, "solid_200");
    pix(10,  230, 1, "solid_10");
    pix(629, 230, 1, "solid_629");
    pix(630, 230, 0, "solid_630");
    pix(9,   230, 0, "solid_9");

    repeat (5) step();
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d checks pending, expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
